// File: rtl/ula_serial_seq.sv
// ula_serial_seq: bit-serial 8-bit ADD / SUB / CMP_LE sequencer driving an
// external 1-bit ALU slice through the sl_* port group.
// Optional build macro: ULA_SEQ_FLAGS_EN adds registered carry/zero flags;
// without it carry and zero are tied to 0.
module ula_serial_seq (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       sl_a,
  output logic       sl_b,
  output logic       sl_arit,
  output logic       sl_comp,
  output logic       sl_x1,
  output logic       sl_x2,
  input  logic       sl_ts,
  input  logic       sl_igual,
  input  logic       sl_f0,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       carry,
  output logic       zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_CMP = 2'b10,
    OP_RSV = 2'b11
  } op_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  op_t        op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       cy_q, cy_d;     // carry from the previous bit
  logic       eq_q, eq_d;     // equal-so-far for CMP_LE
  logic       dec_q, dec_d;   // latched CMP_LE decision
  logic [7:0] sh_q, sh_d;     // result bits collected LSB-first
  logic [7:0] result_q, result_d;
  logic       carry_d, zero_d;
  logic [2:0] idx;

  // Slice drives: derived only from registered state, never from slice outputs
  always_comb begin
    sl_a    = 1'b0;
    sl_b    = 1'b0;
    sl_arit = 1'b0;
    sl_comp = 1'b0;
    sl_x1   = 1'b0;
    sl_x2   = 1'b0;
    idx     = (op_q == OP_CMP) ? ~cnt_q : cnt_q;
    if (state_q == S_RUN) begin
      case (op_q)
        OP_ADD: begin
          sl_a    = a_q[idx];
          sl_b    = b_q[idx];
          sl_arit = (cnt_q == 3'd0) ? 1'b0 : cy_q;
        end
        OP_SUB: begin
          sl_a    = a_q[idx];
          sl_b    = ~b_q[idx];
          sl_arit = (cnt_q == 3'd0) ? 1'b1 : cy_q;
        end
        OP_CMP: begin
          sl_a    = a_q[idx];
          sl_b    = b_q[idx];
          sl_comp = 1'b1;
          sl_x1   = 1'b1;
          sl_x2   = eq_q;
        end
        default: ;
      endcase
    end
  end

  // Next-state, operand capture and per-bit accumulation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cy_d     = cy_q;
    eq_d     = eq_q;
    dec_d    = dec_q;
    sh_d     = sh_q;
    result_d = result_q;
    carry_d  = 1'b0;
    zero_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          op_d    = op_t'(op);
          a_d     = a;
          b_d     = b;
          cy_d    = 1'b0;
          eq_d    = 1'b1;
          dec_d   = 1'b0;
          sh_d    = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 3'd1;
        cy_d  = sl_ts;
        eq_d  = eq_q & sl_igual;
        if (eq_q && !sl_igual) dec_d = sl_f0;
        sh_d  = {sl_f0, sh_q[7:1]};
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
          // Final bit is folded in here so result moves only on DONE entry
          case (op_q)
            OP_ADD, OP_SUB: begin
              result_d = {sl_f0, sh_q[7:1]};
              carry_d  = sl_ts;
            end
            OP_CMP:  result_d = {7'b0, (eq_q & sl_igual) ? 1'b1 : dec_d};
            default: result_d = '0;
          endcase
          zero_d = (result_d == 8'h00);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      cy_q     <= 1'b0;
      eq_q     <= 1'b0;
      dec_q    <= 1'b0;
      sh_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cy_q     <= cy_d;
      eq_q     <= eq_d;
      dec_q    <= dec_d;
      sh_q     <= sh_d;
      result_q <= result_d;
    end
  end

`ifdef ULA_SEQ_FLAGS_EN
  logic carry_q, zero_q;

  // Flags load together with result on DONE entry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (state_q == S_RUN && cnt_q == 3'd7) begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign carry = carry_q;
  assign zero  = zero_q;
`else
  logic unused_flags;
  assign unused_flags = carry_d ^ zero_d;
  assign carry = 1'b0;
  assign zero  = 1'b0;
`endif

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_ula_serial_seq.sv
// Bench for ula_serial_seq with a behavioural 1-bit ALU slice on sl_*.
module tb_ula_serial_seq;

  logic       clock, reset, start;
  logic [1:0] op;
  logic [7:0] a, b;
  logic       sl_a, sl_b, sl_arit, sl_comp, sl_x1, sl_x2;
  logic       sl_ts, sl_igual, sl_f0;
  logic       busy, done, carry, zero;
  logic [7:0] result;

  typedef struct packed {
    logic [7:0] res;
    logic       cy;
    logic       z;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] last_res;

  ula_serial_seq dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .sl_a(sl_a), .sl_b(sl_b), .sl_arit(sl_arit), .sl_comp(sl_comp),
    .sl_x1(sl_x1), .sl_x2(sl_x2), .sl_ts(sl_ts), .sl_igual(sl_igual),
    .sl_f0(sl_f0), .busy(busy), .done(done), .result(result),
    .carry(carry), .zero(zero)
  );

  // 1-bit ALU slice: full adder, or A<B-at-this-bit in compare mode
  assign sl_ts    = (sl_a & sl_b) | (sl_arit & (sl_a ^ sl_b));
  assign sl_igual = sl_x2 & ~(sl_a ^ sl_b);
  assign sl_f0    = sl_x1 ? (sl_comp & ~sl_a & sl_b) : (sl_a ^ sl_b ^ sl_arit);

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic exp_t model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    logic [8:0] s;
    e = '0;
    case (o)
      2'b00: begin s = {1'b0, x} + {1'b0, y}; e.res = s[7:0]; e.cy = s[8]; end
      2'b01: begin e.res = x - y; e.cy = (x >= y); end
      2'b10: e.res = (x <= y) ? 8'h01 : 8'h00;
      default: e.res = 8'h00;
    endcase
    e.z = (e.res == 8'h00);
`ifndef ULA_SEQ_FLAGS_EN
    e.cy = 1'b0;
    e.z  = 1'b0;
`endif
    return e;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        input int ign_cyc);
    logic [7:0] prev;
    int         cyc;
    bit         got;
    exp_t       e;
    prev = result;
    @(negedge clock);
    op = o; a = x; b = y; start = 1'b1;
    sb.push_back(model(o, x, y));
    @(negedge clock);
    start = 1'b0; a = ~x; b = ~y; op = ~o;
    cyc = 1;
    got = 0;
    while (cyc <= 20 && !got) begin
      start = (cyc == ign_cyc);
      if (cyc == ign_cyc) begin
        a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
      end
      if (done === 1'b1) got = 1;
      else begin
        total++;
        if (busy !== 1'b1) begin
          bad++; $display("FAIL busy_run: cycle %0d busy=%b want 1", cyc, busy);
        end
        if (cyc == 4) begin
          total++;
          if (result !== prev) begin
            bad++; $display("FAIL result_held: got %h want %h", result, prev);
          end
        end
        @(negedge clock);
        cyc++;
      end
    end
    start = 1'b0;
    total++;
    if (!got || cyc != 9) begin
      bad++; $display("FAIL done_cycle: got cycle %0d (seen=%0d) want 9", cyc, got);
    end
    if (got) begin
      total++;
      if ({busy, sl_a, sl_b, sl_arit, sl_comp, sl_x1, sl_x2} !== 7'b0) begin
        bad++; $display("FAIL done_quiet: busy/sl=%b want 0000000",
                        {busy, sl_a, sl_b, sl_arit, sl_comp, sl_x1, sl_x2});
      end
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL sb_empty: done with no expected entry");
      end else begin
        e = sb.pop_front();
        if ({result, carry, zero} !== {e.res, e.cy, e.z}) begin
          bad++; $display("FAIL result: op=%b a=%h b=%h got res=%h c=%b z=%b want res=%h c=%b z=%b",
                          o, x, y, result, carry, zero, e.res, e.cy, e.z);
        end
      end
    end
    last_res = result;
    @(negedge clock);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== last_res) begin
      bad++; $display("FAIL after_done: done=%b busy=%b res=%h want 0 0 %h",
                      done, busy, result, last_res);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clock);
    total++;
    if ({busy, done, result, carry, zero, sl_a, sl_b, sl_arit, sl_comp, sl_x1, sl_x2} !== '0) begin
      bad++; $display("FAIL reset_state: busy=%b done=%b res=%h c=%b z=%b want all 0",
                      busy, done, result, carry, zero);
    end
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
      bad++; $display("FAIL idle_state: busy=%b done=%b res=%h want 0 0 00", busy, done, result);
    end
  endtask

  task automatic test_add;
    run_op(2'b00, 8'h3C, 8'h05, 0);
    total++;
    if (last_res !== 8'h41) begin bad++; $display("FAIL add_3c_05: got %h want 41", last_res); end
    run_op(2'b00, 8'hFF, 8'h01, 0);
    total++;
    if (last_res !== 8'h00) begin bad++; $display("FAIL add_ff_01: got %h want 00", last_res); end
  endtask

  task automatic test_sub;
    run_op(2'b01, 8'h10, 8'h01, 0);
    total++;
    if (last_res !== 8'h0F) begin bad++; $display("FAIL sub_10_01: got %h want 0f", last_res); end
    run_op(2'b01, 8'h01, 8'h02, 0);
    total++;
    if (last_res !== 8'hFF) begin bad++; $display("FAIL sub_01_02: got %h want ff", last_res); end
  endtask

  task automatic test_cmp;
    run_op(2'b10, 8'h20, 8'h30, 0);
    total++;
    if (last_res !== 8'h01) begin bad++; $display("FAIL cmp_lt: got %h want 01", last_res); end
    run_op(2'b10, 8'h30, 8'h20, 0);
    total++;
    if (last_res !== 8'h00) begin bad++; $display("FAIL cmp_gt: got %h want 00", last_res); end
    run_op(2'b10, 8'h5A, 8'h5A, 0);
    total++;
    if (last_res !== 8'h01) begin bad++; $display("FAIL cmp_eq: got %h want 01", last_res); end
  endtask

  task automatic test_reserved;
    run_op(2'b11, 8'hA5, 8'h3C, 0);
  endtask

  task automatic test_ignore_start;
    run_op(2'b00, 8'h3C, 8'h05, 3);
    total++;
    if (last_res !== 8'h41) begin bad++; $display("FAIL ignore_start: got %h want 41", last_res); end
  endtask

  task automatic test_reset_abort;
    bit seen;
    @(negedge clock);
    op = 2'b00; a = 8'h12; b = 8'h34; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, result, carry, zero, sl_a, sl_b, sl_arit, sl_comp, sl_x1, sl_x2} !== '0) begin
      bad++; $display("FAIL reset_abort: busy=%b done=%b res=%h c=%b z=%b want all 0",
                      busy, done, result, carry, zero);
    end
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    total++;
    if (seen || result !== 8'h00) begin
      bad++; $display("FAIL abort_quiet: activity=%0d res=%h want 0 00", seen, result);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++)
      run_op(2'($urandom), 8'($urandom), 8'($urandom), 0);
    run_op(2'b00, 8'h80, 8'h80, 0);
    run_op(2'b10, 8'h00, 8'hFF, 0);
    run_op(2'b10, 8'hFF, 8'h00, 0);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_cmp;
    test_reserved;
    test_ignore_start;
    test_reset_abort;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
